// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO-draining UART transmitter
//
// Pops one word at a time from the upstream synchronous FIFO and sends it as an
// asynchronous frame: start bit, DATA_WIDTH data bits LSB first, optional even
// parity bit, stop bit. Each bit lasts CLKS_PER_BIT clocks.
//
// Optional feature macro: FIFO_UART_TX_PARITY_EN (inserts an even-parity bit).
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high
//   fifo_empty    FIFO empty flag
//   fifo_rd_data  FIFO read data, valid the cycle after a pop
//   fifo_rd_en    single-cycle pop strobe to the FIFO
//   tx            serial line, idles high
//   busy          high from the pop until the end of the stop bit
//   tx_done       one-cycle pulse after the stop bit completes
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LOAD,
        START,
        DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                  state, state_n;
    logic [BAUD_W-1:0]       baud, baud_n;
    logic [BIT_W-1:0]        bit_idx, bit_n;
    logic [DATA_WIDTH-1:0]   shreg, shreg_n;
    logic                    tx_n;
    logic                    done_n;
    logic                    baud_end;

`ifdef FIFO_UART_TX_PARITY_EN
    // Parity is taken from the word at capture time because the shift register
    // is consumed while the data bits go out.
    logic                    parity;
`endif

    assign baud_end = (baud == BAUD_LAST);

    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_idx;
        shreg_n = shreg;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_n = RD;
                end
            end
            RD: begin
                state_n = LOAD;
            end
            LOAD: begin
                state_n = START;
                shreg_n = fifo_rd_data;
                baud_n  = '0;
            end
            START: begin
                if (baud_end) begin
                    state_n = DATA;
                    baud_n  = '0;
                    bit_n   = '0;
                end else begin
                    baud_n = baud + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_n = '0;
                    if (bit_idx == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n   = bit_idx + BIT_W'(1);
                        shreg_n = shreg >> 1;
                    end
                end else begin
                    baud_n = baud + BAUD_W'(1);
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    state_n = STOP;
                    baud_n  = '0;
                end else begin
                    baud_n = baud + BAUD_W'(1);
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    state_n = IDLE;
                    baud_n  = '0;
                    done_n  = 1'b1;
                end else begin
                    baud_n = baud + BAUD_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // tx is registered from the next-state view so the line changes
        // exactly on bit boundaries with no combinational path to the pin.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  tx_n = parity;
`endif
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            baud       <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            fifo_rd_en <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_n;
            baud       <= baud_n;
            bit_idx    <= bit_n;
            shreg      <= shreg_n;
            tx         <= tx_n;
            busy       <= (state_n != IDLE);
            fifo_rd_en <= (state_n == RD);
            tx_done    <= done_n;
        end
    end

`ifdef FIFO_UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            parity <= 1'b0;
        end else if (state == LOAD) begin
            parity <= ^fifo_rd_data;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed self-checking bench for fifo_uart_tx
//
// Models the upstream FIFO (registered read data and empty flag), drives
// directed words and compares every tx cycle against hand-known frames.
module tb_fifo_uart_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = DW + 3;
`else
    localparam int NBITS = DW + 2;
`endif
    localparam int FLEN = NBITS * CPB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_en;
    logic          tx;
    logic          busy;
    logic          tx_done;

    logic          push_req = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic [DW-1:0] fifo_q[$];

    int total = 0;
    int bad = 0;
    int pops = 0;
    int underflows = 0;
    int dones = 0;

    fifo_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en  (fifo_rd_en),
        .tx          (tx),
        .busy        (busy),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (push_req) fifo_q.push_back(push_data);
        if (fifo_rd_en) begin
            pops <= pops + 1;
            if (fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
            else underflows <= underflows + 1;
        end
        fifo_empty <= (fifo_q.size() == 0);
        if (tx_done) dones <= dones + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] b);
        push_data = b;
        push_req  = 1'b1;
        @(negedge clk);
        push_req  = 1'b0;
    endtask

    // Waits (bounded) for a start bit, then checks every cycle of the frame and
    // the tx_done pulse. gap = number of high cycles seen before the start bit.
    task automatic expect_frame(input logic [DW-1:0] b, input logic par,
                                input string tag, output int gap);
        int   n;
        int   j;
        logic e;
        n = 0;
        while (tx === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        gap = n;
        if (n >= 200) begin
            check($sformatf("%s_start_timeout", tag), 1, 0);
            return;
        end
        for (int c = 0; c < FLEN; c++) begin
            if (c > 0) @(negedge clk);
            j = c / CPB;
            if (j == 0)              e = 1'b0;
            else if (j <= DW)        e = b[j-1];
            else if (j == NBITS - 1) e = 1'b1;
            else                     e = par;
            check($sformatf("%s_tx_c%0d", tag, c), tx, e);
        end
        check($sformatf("%s_busy_last_stop", tag), busy, 1);
        @(negedge clk);
        check($sformatf("%s_done_pulse", tag), tx_done, 1);
        check($sformatf("%s_busy_after", tag), busy, 0);
        check($sformatf("%s_tx_after", tag), tx, 1);
    endtask

    logic [DW-1:0] words[4] = '{8'h5D, 8'hD4, 8'hF3, 8'h0D};
    logic          pars[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int gap;
        int bad_tx;
        int bad_busy;
        int bad_rd;

        // Reset held with a non-empty FIFO.
        repeat (2) @(negedge clk);
        push_word(8'h5D);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_tx_%0d", i), tx, 1);
            check($sformatf("reset_busy_%0d", i), busy, 0);
            check($sformatf("reset_rd_en_%0d", i), fifo_rd_en, 0);
            check($sformatf("reset_done_%0d", i), tx_done, 0);
            @(negedge clk);
        end
        reset = 1'b0;

        // Single word.
        expect_frame(8'h5D, 1'b1, "single", gap);
        @(negedge clk);
        check("single_pops", pops, 1);
        check("single_dones", dones, 1);

        // Four preloaded words, back to back.
        for (int k = 0; k < 4; k++) push_word(words[k]);
        for (int k = 0; k < 4; k++) begin
            expect_frame(words[k], pars[k], $sformatf("multi%0d", k), gap);
            if (k > 0) check($sformatf("multi%0d_gap", k), gap, 3);
        end
        repeat (10) @(negedge clk);
        check("multi_pops", pops, 5);
        check("multi_dones", dones, 5);
        check("multi_underflow", underflows, 0);
        check("multi_empty", fifo_empty, 1);

        // Reset during data bit 3 of 8'hD4, then 8'h0D must go out intact.
        push_word(8'hD4);
        push_word(8'h0D);
        gap = 0;
        while (tx === 1'b1 && gap < 200) begin
            gap++;
            @(negedge clk);
        end
        check("midreset_start_seen", (gap < 200), 1);
        repeat (17) @(negedge clk);
        check("midreset_bit3_value", tx, 0);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_tx", tx, 1);
        check("midreset_busy", busy, 0);
        check("midreset_rd_en", fifo_rd_en, 0);
        check("midreset_done", tx_done, 0);
        reset = 1'b0;
        expect_frame(8'h0D, 1'b1, "after_reset", gap);
        repeat (5) @(negedge clk);
        check("midreset_pops", pops, 7);
        check("midreset_dones", dones, 6);
        check("midreset_underflow", underflows, 0);

        // Empty FIFO for 50 cycles.
        bad_tx = 0;
        bad_busy = 0;
        bad_rd = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
            if (fifo_rd_en !== 1'b0) bad_rd++;
        end
        check("empty_tx_low_cycles", bad_tx, 0);
        check("empty_busy_cycles", bad_busy, 0);
        check("empty_rd_en_cycles", bad_rd, 0);
        check("empty_pops", pops, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
